// File: rtl/ysyx_25020037_ifu_if.sv
// Fetch-side bundle: decode handshake, execute redirect and the AXI4-Lite-style
// instruction read channels, grouped so the IFU and its neighbours share one port.
interface ysyx_25020037_ifu_if;
    logic        idu_ready;
    logic        ifu_valid;
    logic [63:0] fu_to_du_bus;
    logic        exu_dnpc_valid;
    logic [31:0] exu_dnpc;
    logic        ifu_arvalid;
    logic [31:0] ifu_araddr;
    logic        ifu_arready;
    logic        ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rready;

    modport master (
        input  idu_ready,
        output ifu_valid,
        output fu_to_du_bus,
        input  exu_dnpc_valid,
        input  exu_dnpc,
        output ifu_arvalid,
        output ifu_araddr,
        input  ifu_arready,
        input  ifu_rvalid,
        input  ifu_rdata,
        input  ifu_rresp,
        output ifu_rready
    );

    modport slave (
        output idu_ready,
        input  ifu_valid,
        input  fu_to_du_bus,
        output exu_dnpc_valid,
        output exu_dnpc,
        input  ifu_arvalid,
        input  ifu_araddr,
        output ifu_arready,
        output ifu_rvalid,
        output ifu_rdata,
        output ifu_rresp,
        input  ifu_rready
    );
endinterface

// File: rtl/ysyx_25020037_ifu.sv
// Instruction fetch unit: one outstanding instruction read at a time, bundle held for decode.
// Optional macro YSYX_25020037_IFU_PERF_EN adds fetch/stall performance counters.
module ysyx_25020037_ifu #(
    parameter logic [31:0] RESET_PC = 32'h3000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic                         clk,
    input  logic                         rst_n,
`ifdef YSYX_25020037_IFU_PERF_EN
    output logic [31:0]                  perf_fetch_cnt,
    output logic [31:0]                  perf_stall_cnt,
`endif
    ysyx_25020037_ifu_if.master          bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic        r_valid;
    logic        w_valid_nxt;
    logic [63:0] r_bus;
    logic [63:0] w_bus_nxt;
    logic        r_flush;
    logic        w_flush_nxt;
    logic [31:0] r_target;
    logic [31:0] w_target_nxt;
    logic        r_arvalid;
    logic        w_arvalid_nxt;
    logic        r_rready;
    logic        w_rready_nxt;
    logic [31:0] w_inst;

    // An error response turns the instruction into all-zeros for decode to reject.
    always_comb begin
        if (bus.ifu_rresp == 2'b00) begin
            w_inst = bus.ifu_rdata;
        end else begin
            w_inst = 32'h0000_0000;
        end
    end

    // Next-state and next-register values for the fetch FSM.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_valid_nxt  = r_valid;
        w_bus_nxt    = r_bus;
        w_flush_nxt  = r_flush;
        w_target_nxt = r_target;
        case (r_state)
            IDLE: begin
                w_state_nxt = AR;
                if (bus.exu_dnpc_valid) begin
                    w_pc_nxt = bus.exu_dnpc;
                end else begin
                    w_pc_nxt = r_pc;
                end
            end
            AR: begin
                // arvalid cannot be withdrawn, so a redirect only marks this fetch stale.
                if (bus.exu_dnpc_valid) begin
                    w_flush_nxt  = 1'b1;
                    w_target_nxt = bus.exu_dnpc;
                end else begin
                    w_flush_nxt  = r_flush;
                    w_target_nxt = r_target;
                end
                if (bus.ifu_arready) begin
                    w_state_nxt = R;
                end else begin
                    w_state_nxt = AR;
                end
            end
            R: begin
                if (bus.ifu_rvalid) begin
                    if (!r_flush && !bus.exu_dnpc_valid) begin
                        w_bus_nxt   = {r_pc, w_inst};
                        w_valid_nxt = 1'b1;
                        w_state_nxt = HOLD;
                    end else begin
                        // A redirect in the same cycle as the data is the newest target.
                        if (bus.exu_dnpc_valid) begin
                            w_pc_nxt = bus.exu_dnpc;
                        end else begin
                            w_pc_nxt = r_target;
                        end
                        w_flush_nxt = 1'b0;
                        w_state_nxt = AR;
                    end
                end else begin
                    if (bus.exu_dnpc_valid) begin
                        w_flush_nxt  = 1'b1;
                        w_target_nxt = bus.exu_dnpc;
                    end else begin
                        w_flush_nxt  = r_flush;
                        w_target_nxt = r_target;
                    end
                    w_state_nxt = R;
                end
            end
            HOLD: begin
                if (bus.exu_dnpc_valid) begin
                    w_valid_nxt = 1'b0;
                    w_pc_nxt    = bus.exu_dnpc;
                    w_state_nxt = AR;
                end else if (bus.idu_ready) begin
                    w_valid_nxt = 1'b0;
                    w_pc_nxt    = r_pc + PC_STEP;
                    w_state_nxt = AR;
                end else begin
                    w_state_nxt = HOLD;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_arvalid_nxt = (w_state_nxt == AR);
        w_rready_nxt  = (w_state_nxt == R);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_valid   <= 1'b0;
            r_bus     <= 64'h0;
            r_flush   <= 1'b0;
            r_target  <= 32'h0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
        end else begin
            r_pc      <= w_pc_nxt;
            r_valid   <= w_valid_nxt;
            r_bus     <= w_bus_nxt;
            r_flush   <= w_flush_nxt;
            r_target  <= w_target_nxt;
            r_arvalid <= w_arvalid_nxt;
            r_rready  <= w_rready_nxt;
        end
    end

    assign bus.ifu_valid    = r_valid;
    assign bus.fu_to_du_bus = r_bus;
    assign bus.ifu_arvalid  = r_arvalid;
    assign bus.ifu_araddr   = r_pc;
    assign bus.ifu_rready   = r_rready;

`ifdef YSYX_25020037_IFU_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    // Accepted-bundle and memory-wait cycle counters, free-running with wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt <= 32'h0;
            r_stall_cnt <= 32'h0;
        end else begin
            if (r_valid && bus.idu_ready) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end else begin
                r_fetch_cnt <= r_fetch_cnt;
            end
            if ((r_state == AR) || (r_state == R)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
        end
    end

    assign perf_fetch_cnt = r_fetch_cnt;
    assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ysyx_25020037_ifu.sv
// Directed bench for the fetch unit: fetch/hold, redirects in every state, error
// response, PC wrap and reset during an outstanding read.
module tb_ysyx_25020037_ifu;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    ysyx_25020037_ifu_if ifc();

`ifdef YSYX_25020037_IFU_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    ysyx_25020037_ifu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .bus            (ifc.master)
    );
`else
    ysyx_25020037_ifu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.master)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    // Accept the address now and return data on the following cycle.
    task automatic serve(input logic [31:0] data, input logic [1:0] resp);
        ifc.ifu_arready = 1'b1;
        tick();
        ifc.ifu_arready = 1'b0;
        ifc.ifu_rvalid  = 1'b1;
        ifc.ifu_rdata   = data;
        ifc.ifu_rresp   = resp;
        tick();
        ifc.ifu_rvalid  = 1'b0;
        ifc.ifu_rresp   = 2'b00;
    endtask

    initial begin
        logic [63:0] held;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        ifc.idu_ready      = 1'b0;
        ifc.exu_dnpc_valid = 1'b0;
        ifc.exu_dnpc       = 32'h0;
        ifc.ifu_arready    = 1'b0;
        ifc.ifu_rvalid     = 1'b0;
        ifc.ifu_rdata      = 32'h0;
        ifc.ifu_rresp      = 2'b00;
        tick();
        tick();
        chk("rst_valid",   {63'd0, ifc.ifu_valid},   64'd0);
        chk("rst_bus",     ifc.fu_to_du_bus,         64'd0);
        chk("rst_arvalid", {63'd0, ifc.ifu_arvalid}, 64'd0);
        chk("rst_rready",  {63'd0, ifc.ifu_rready},  64'd0);
        chk("rst_araddr",  {32'd0, ifc.ifu_araddr},  64'h3000_0000);

        // First fetch after reset release.
        rst_n = 1'b1;
        tick();
        chk("f1_arvalid", {63'd0, ifc.ifu_arvalid}, 64'd1);
        chk("f1_araddr",  {32'd0, ifc.ifu_araddr},  64'h3000_0000);
        ifc.ifu_arready = 1'b1;
        tick();
        ifc.ifu_arready = 1'b0;
        chk("f1_r_rready",  {63'd0, ifc.ifu_rready},  64'd1);
        chk("f1_r_arvalid", {63'd0, ifc.ifu_arvalid}, 64'd0);
        ifc.ifu_rvalid = 1'b1;
        ifc.ifu_rdata  = 32'h0000_0413;
        tick();
        ifc.ifu_rvalid = 1'b0;
        chk("f1_valid", {63'd0, ifc.ifu_valid}, 64'd1);
        chk("f1_bus",   ifc.fu_to_du_bus,       64'h3000_0000_0000_0413);
        ifc.idu_ready = 1'b1;
        tick();
        ifc.idu_ready = 1'b0;
        chk("f1_next_araddr", {32'd0, ifc.ifu_araddr}, 64'h3000_0004);
        chk("f1_next_valid",  {63'd0, ifc.ifu_valid},  64'd0);

        // Decode stalls for five cycles: the bundle must not move.
        serve(32'h0010_0093, 2'b00);
        held = ifc.fu_to_du_bus;
        chk("stall_bus0", held, 64'h3000_0004_0010_0093);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid",   {63'd0, ifc.ifu_valid},   64'd1);
            chk("stall_bus",     ifc.fu_to_du_bus,         64'h3000_0004_0010_0093);
            chk("stall_arvalid", {63'd0, ifc.ifu_arvalid}, 64'd0);
            tick();
        end
        ifc.idu_ready = 1'b1;
        tick();
        ifc.idu_ready = 1'b0;
        chk("stall_next_araddr", {32'd0, ifc.ifu_araddr}, 64'h3000_0008);

        // Error response yields a zero instruction.
        serve(32'h1234_5678, 2'b10);
        chk("rresp_valid", {63'd0, ifc.ifu_valid}, 64'd1);
        chk("rresp_bus",   ifc.fu_to_du_bus,       64'h3000_0008_0000_0000);

        // Redirect beats idu_ready in HOLD.
        ifc.idu_ready      = 1'b1;
        ifc.exu_dnpc_valid = 1'b1;
        ifc.exu_dnpc       = 32'h3000_0040;
        tick();
        ifc.idu_ready      = 1'b0;
        ifc.exu_dnpc_valid = 1'b0;
        chk("hold_redir_araddr", {32'd0, ifc.ifu_araddr}, 64'h3000_0040);
        chk("hold_redir_valid",  {63'd0, ifc.ifu_valid},  64'd0);

        // Redirect during R: the late data must be discarded.
        ifc.ifu_arready = 1'b1;
        tick();
        ifc.ifu_arready    = 1'b0;
        ifc.exu_dnpc_valid = 1'b1;
        ifc.exu_dnpc       = 32'h8000_0100;
        tick();
        ifc.exu_dnpc_valid = 1'b0;
        chk("rflush_valid0",  {63'd0, ifc.ifu_valid},  64'd0);
        chk("rflush_rready0", {63'd0, ifc.ifu_rready}, 64'd1);
        tick();
        chk("rflush_valid1", {63'd0, ifc.ifu_valid}, 64'd0);
        ifc.ifu_rvalid = 1'b1;
        ifc.ifu_rdata  = 32'hDEAD_BEEF;
        tick();
        ifc.ifu_rvalid = 1'b0;
        chk("rflush_valid2",  {63'd0, ifc.ifu_valid},   64'd0);
        chk("rflush_arvalid", {63'd0, ifc.ifu_arvalid}, 64'd1);
        chk("rflush_araddr",  {32'd0, ifc.ifu_araddr},  64'h8000_0100);
        tick();
        chk("rflush_valid3", {63'd0, ifc.ifu_valid}, 64'd0);

        // Redirect during AR keeps the address stable; a second redirect wins.
        ifc.exu_dnpc_valid = 1'b1;
        ifc.exu_dnpc       = 32'h9000_0000;
        tick();
        chk("arflush_arvalid", {63'd0, ifc.ifu_arvalid}, 64'd1);
        chk("arflush_araddr",  {32'd0, ifc.ifu_araddr},  64'h8000_0100);
        ifc.exu_dnpc       = 32'h9000_0010;
        ifc.ifu_arready    = 1'b1;
        tick();
        ifc.exu_dnpc_valid = 1'b0;
        ifc.ifu_arready    = 1'b0;
        ifc.ifu_rvalid     = 1'b1;
        ifc.ifu_rdata      = 32'hCAFE_F00D;
        tick();
        ifc.ifu_rvalid = 1'b0;
        chk("lastwin_valid",  {63'd0, ifc.ifu_valid},  64'd0);
        chk("lastwin_araddr", {32'd0, ifc.ifu_araddr}, 64'h9000_0010);
        serve(32'h0000_0013, 2'b00);
        chk("lastwin_bus", ifc.fu_to_du_bus, 64'h9000_0010_0000_0013);

        // PC wraps at the top of the address space.
        ifc.exu_dnpc_valid = 1'b1;
        ifc.exu_dnpc       = 32'hFFFF_FFFC;
        tick();
        ifc.exu_dnpc_valid = 1'b0;
        chk("wrap_araddr0", {32'd0, ifc.ifu_araddr}, 64'hFFFF_FFFC);
        serve(32'h0000_0073, 2'b00);
        chk("wrap_bus", ifc.fu_to_du_bus, 64'hFFFF_FFFC_0000_0073);
        ifc.idu_ready = 1'b1;
        tick();
        ifc.idu_ready = 1'b0;
        chk("wrap_araddr1", {32'd0, ifc.ifu_araddr}, 64'h0000_0000);

        // Reset while waiting for read data, with a stale response arriving later.
        ifc.ifu_arready = 1'b1;
        tick();
        ifc.ifu_arready = 1'b0;
        chk("mid_rready", {63'd0, ifc.ifu_rready}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rready",  {63'd0, ifc.ifu_rready},  64'd0);
        chk("mid_rst_arvalid", {63'd0, ifc.ifu_arvalid}, 64'd0);
        chk("mid_rst_araddr",  {32'd0, ifc.ifu_araddr},  64'h3000_0000);
        chk("mid_rst_bus",     ifc.fu_to_du_bus,         64'd0);
        ifc.ifu_rvalid = 1'b1;
        ifc.ifu_rdata  = 32'hBAD0_BAD0;
        tick();
        rst_n = 1'b1;
        tick();
        ifc.ifu_rvalid = 1'b0;
        chk("restart_valid",   {63'd0, ifc.ifu_valid},   64'd0);
        chk("restart_arvalid", {63'd0, ifc.ifu_arvalid}, 64'd1);
        chk("restart_araddr",  {32'd0, ifc.ifu_araddr},  64'h3000_0000);
        serve(32'h0000_0417, 2'b00);
        chk("restart_bus", ifc.fu_to_du_bus, 64'h3000_0000_0000_0417);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
